// File: rtl/out_port_gpio_if.sv
// Bus bundle for out_port_gpio: the write operand and mode in one direction,
// the pin drive, read-back and busy status in the other.
interface out_port_gpio_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] write_data;
  logic             write_enable;
  logic [2:0]       mode;
  logic [WIDTH-1:0] out_lines;
  logic [WIDTH-1:0] read_data;
  logic             busy;

  modport master (
    output write_data, write_enable, mode,
    input  out_lines, read_data, busy
  );

  modport slave (
    input  write_data, write_enable, mode,
    output out_lines, read_data, busy
  );
endinterface

// File: rtl/out_port_gpio.sv
// Output port with a data register plus set/clear/toggle writes and a
// retriggerable fixed-length pulse overlay on selected lines.
module out_port_gpio #(
  parameter int WIDTH   = 8,
  parameter int PULSE_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  out_port_gpio_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_WRITE    = 3'b000,
    MODE_SET      = 3'b001,
    MODE_CLEAR    = 3'b010,
    MODE_TOGGLE   = 3'b011,
    MODE_LOAD_LEN = 3'b100,
    MODE_FIRE     = 3'b101
  } mode_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PULSING = 1'b1
  } state_t;

  logic [WIDTH-1:0]   r_data_reg;
  logic [WIDTH-1:0]   r_pulse_mask;
  logic [PULSE_W-1:0] r_pulse_len;
  logic [PULSE_W-1:0] r_count;
  state_t             r_state;

  logic [WIDTH-1:0]   w_data;
  logic [WIDTH-1:0]   w_mask;
  logic [PULSE_W-1:0] w_len;
  logic [PULSE_W-1:0] w_count;
  state_t             w_state;
  logic [PULSE_W-1:0] w_len_op;
  logic               w_fire;

  // Pulse length comes from the low bits of the operand, zero-extended on narrow ports.
  generate
    if (WIDTH >= PULSE_W) begin : g_len_trunc
      assign w_len_op = bus.write_data[PULSE_W-1:0];
    end else begin : g_len_ext
      assign w_len_op = {{(PULSE_W-WIDTH){1'b0}}, bus.write_data};
    end
  endgenerate

  assign w_fire = bus.write_enable && (bus.mode == MODE_FIRE) &&
                  (r_pulse_len != '0) && (bus.write_data != '0);

  // NOTE: every next-state variable gets a default first so no path infers a latch.
  always_comb begin
    w_data  = r_data_reg;
    w_mask  = r_pulse_mask;
    w_len   = r_pulse_len;
    w_count = r_count;
    w_state = r_state;

    if (r_state == PULSING && !w_fire) begin
      if (r_count <= PULSE_W'(1)) begin
        w_mask  = '0;
        w_count = '0;
        w_state = IDLE;
      end else begin
        w_count = r_count - PULSE_W'(1);
      end
    end

    if (bus.write_enable) begin
      case (bus.mode)
        MODE_WRITE:    w_data = bus.write_data;
        MODE_SET:      w_data = r_data_reg | bus.write_data;
        MODE_TOGGLE:   w_data = r_data_reg ^ bus.write_data;
        MODE_LOAD_LEN: w_len  = w_len_op;
        MODE_CLEAR: begin
          w_data = r_data_reg & ~bus.write_data;
          w_mask = w_mask & ~bus.write_data;
          if (w_mask == '0) begin
            w_count = '0;
            w_state = IDLE;
          end
        end
        MODE_FIRE: begin
          if (w_fire) begin
            w_mask  = r_pulse_mask | bus.write_data;
            w_count = r_pulse_len;
            w_state = PULSING;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_reg   <= '0;
      r_pulse_mask <= '0;
      r_pulse_len  <= '0;
      r_count      <= '0;
      r_state      <= IDLE;
    end else begin
      r_data_reg   <= w_data;
      r_pulse_mask <= w_mask;
      r_pulse_len  <= w_len;
      r_count      <= w_count;
      r_state      <= w_state;
    end
  end

  assign bus.out_lines = r_data_reg | r_pulse_mask;
  assign bus.read_data = r_data_reg;
  assign bus.busy      = (r_state == PULSING);

endmodule

// File: doc/out_port_gpio.md
OUT_PORT_GPIO -- requirements
Module: out_port_gpio

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the number of output lines.
REQ-002 The module SHALL have parameter PULSE_W, default 8, giving the pulse-length counter width.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is the asynchronous, active-high reset.
REQ-005 Port write_data  input  WIDTH  carries the write operand; the pulse-length operand is its low PULSE_W bits, zero-extended if WIDTH < PULSE_W.
REQ-006 Port write_enable  input  1  SHALL qualify a write for exactly one clk edge.
REQ-007 Port mode  input  3  selects the operation: 000 WRITE, 001 SET, 010 CLEAR, 011 TOGGLE, 100 LOAD_LEN, 101 FIRE, 110/111 reserved.
REQ-008 Port out_lines  output  WIDTH  drives the port pins.
REQ-009 Port read_data  output  WIDTH  returns the data register.
REQ-010 Port busy  output  1  SHALL be high while a pulse is active.

Function
REQ-011 Internal state SHALL consist of: data_reg (WIDTH), pulse_mask (WIDTH), pulse_len (PULSE_W), count (PULSE_W) and an FSM with states IDLE and PULSING.
REQ-012 out_lines SHALL equal data_reg | pulse_mask, registered, and SHALL have no combinational path from write_data.
REQ-013 read_data SHALL equal data_reg; busy SHALL equal (state == PULSING).
REQ-014 With write_enable=0, data_reg, pulse_len and mode-driven state SHALL hold; only the pulse counter logic SHALL advance.
REQ-015 WRITE SHALL set data_reg <= write_data.
REQ-016 SET SHALL set data_reg <= data_reg | write_data.
REQ-017 CLEAR SHALL set data_reg <= data_reg & ~write_data and pulse_mask <= pulse_mask & ~write_data; a pulse whose mask becomes zero SHALL return the FSM to IDLE on the same edge.
REQ-018 TOGGLE SHALL set data_reg <= data_reg ^ write_data.
REQ-019 LOAD_LEN SHALL set pulse_len <= write_data[PULSE_W-1:0]; a pulse already running SHALL keep its count.
REQ-020 FIRE with pulse_len != 0 and write_data != 0 SHALL set pulse_mask <= pulse_mask | write_data, load count <= pulse_len, and enter PULSING.
REQ-021 FIRE with pulse_len == 0 or write_data == 0 SHALL have no effect.
REQ-022 FIRE during PULSING (retrigger) SHALL OR in the new bits and reload count; all masked bits SHALL then end together.
REQ-023 Pulse timing: FIRE accepted at edge N with length L SHALL make the masked bits high after edge N, keep them high through edge N+L-1, and drop them after edge N+L, giving exactly L cycles.
REQ-024 In PULSING, with no FIRE at that edge, count SHALL decrement by 1 per edge; at the edge where count == 1, pulse_mask SHALL clear to 0 and the FSM SHALL enter IDLE.
REQ-025 A bit that is set in both data_reg and pulse_mask SHALL stay high after the pulse ends.
REQ-026 Reserved modes SHALL change no state; the pulse counter SHALL continue to run.
REQ-027 Maximum pulse length SHALL be 2^PULSE_W-1 cycles; count SHALL never wrap.

Reset
REQ-028 While reset=1, independent of clk: data_reg=0, pulse_mask=0, pulse_len=0, count=0, FSM=IDLE; out_lines=0, read_data=0, busy=0.
REQ-029 Reset asserted mid-pulse SHALL abort the pulse immediately; no write is accepted while reset=1.
REQ-030 After reset deasserts, the first write_enable edge SHALL behave normally.

Verification
REQ-031 Reset, then WRITE 0xA5 -> out_lines=0xA5 after that edge; SET 0x0F -> 0xAF; CLEAR 0xA0 -> 0x0F; TOGGLE 0xFF -> 0xF0; read_data tracks each result.
REQ-032 LOAD_LEN 3, FIRE 0x01 with data_reg=0 -> out_lines=0x01 for exactly 3 cycles, then 0x00; busy high for the same 3 cycles.
REQ-033 LOAD_LEN 4, FIRE 0x01, FIRE 0x02 two cycles later -> 0x01 high for 6 cycles total, 0x02 high for 4 cycles, both drop on the same edge.
REQ-034 LOAD_LEN 0, FIRE 0xFF -> no change to out_lines; busy stays 0. Then LOAD_LEN 5, FIRE 0x80, CLEAR 0x80 on the next cycle -> bit 7 drops and busy=0.
REQ-035 data_reg=0x01, LOAD_LEN 2, FIRE 0x03 -> out_lines=0x03 for 2 cycles, then 0x01.
REQ-036 LOAD_LEN 10, FIRE 0x10, assert reset asynchronously 4 cycles later -> out_lines=0 and busy=0 with no clk edge; after release, out_lines stays 0.
